ip_uart_rx: RTL and testbench
=============================

// Module: ip_uart_rx
// PURPOSE
//  UART receiver, 8 data bits, LSB first, 1 stop bit, no parity unless IP_UART_RX_PARITY_EN is defined.
//  Complements the ip_uart transmitter: PC/host serial data enters on uart_rx and becomes bytes for cartridge logic.
//  Holds one received byte behind a valid/ack handshake and reports framing and overrun errors.
// PARAMETERS
//  clk_freq   27000000  sys_clk frequency in Hz
//  uart_freq  115200    baud rate; bit period DIV = clk_freq/uart_freq, truncated (234); HALF = DIV/2 (117)
// PORTS
//  sys_clk        in   1  system clock; all logic on its rising edge
//  w_n_reset      in   1  reset, asynchronous, active-low
//  uart_rx        in   1  serial input, idle high, asynchronous to sys_clk
//  recv_data      out  8  last accepted byte; stable while recv_valid=1
//  recv_valid     out  1  level; byte available in recv_data
//  recv_ack       in   1  one-cycle pulse; consumer has taken recv_data
//  framing_error  out  1  one-cycle pulse; stop bit sampled low
//  overrun        out  1  sticky; a frame completed while recv_valid=1
//  parity_error   out  1  one-cycle pulse; parity mismatch (tied 0 without IP_UART_RX_PARITY_EN)
// BEHAVIOUR
//  Reset: recv_data=0x00, recv_valid=0, framing_error=0, overrun=0, parity_error=0, state=IDLE, sync regs=1.
//  Input: 2-FF synchronizer, then a 3-bit history; a bit value is majority(last 3 synced samples) at the sample point.
//  Bit counter: down-counter that reloads to DIV-1 at each sample point; bit index 0..7.
//  FSM:
//   IDLE: on synced rx=0, load counter HALF-1 and go to START.
//   START: at counter=0, sample. 1 -> false start, go to IDLE with no output. 0 -> reload DIV-1, idx=0, go to DATA.
//   DATA: at each counter=0, shift sample into bit idx (LSB first). After idx 7, go to PARITY if enabled, else STOP.
//   PARITY: at counter=0, sample and compare with even parity of the 8 data bits. Go to STOP.
//   STOP: at counter=0, sample.
//    1 -> frame OK. If recv_valid=0: recv_data<=byte, recv_valid<=1. If recv_valid=1: recv_data unchanged, overrun<=1, byte dropped.
//    0 -> framing_error=1 for one cycle, byte discarded, go to BREAK.
//    From STOP (sample 1), return to IDLE.
//   BREAK: stay until synced rx=1, then go to IDLE. A held-low line does not retrigger.
//  Latency: outputs register on the cycle after the stop-bit sample point, about 9.5 bit times after the start edge
//   (10.5 with parity), plus 2 synchronizer cycles.
//  Handshake: recv_ack with recv_valid=1 clears recv_valid and overrun on the next edge.
//   recv_ack with recv_valid=0 has no effect.
//  Simultaneous recv_ack and stop-OK in the same cycle: the new byte loads, recv_valid stays 1, overrun is cleared, not set.
//  Parity error: the byte is still delivered if the stop bit is good; parity_error pulses in the same cycle recv_valid rises
//   or overrun sets.
//  Reset mid-frame: immediately returns to the reset values. The next full frame is received normally.
// CONFIGURATION
//  IP_UART_RX_PARITY_EN defined: frame is start + 8 data + even parity + stop; PARITY state active; parity_error is live.
//  IP_UART_RX_PARITY_EN undefined: PARITY state and parity logic are not built; parity_error=0; frame is start + 8 + stop.
// TESTING
//  1) Drive 0x48 at 115200 baud (DIV=234) -> recv_valid=1, recv_data=0x48, framing_error never 1.
//  2) Pulse uart_rx low for 50 cycles, then high -> FSM back in IDLE, recv_valid stays 0, no error pulses.
//  3) Send 0x55 with stop bit 0, then hold low for 2000 cycles, then release -> one framing_error pulse, recv_valid=0,
//     no second frame, next 0x21 received correctly.
//  4) Send 0x57 then 0x4F without ack -> recv_data=0x57, overrun=1; pulse recv_ack -> recv_valid=0, overrun=0.
//  5) Assert w_n_reset low during data bit 4 of 0xA5 -> all outputs 0; after release, 0x3C is received intact.
//  6) Loopback from ip_uart sending "HELLO! WORLD " (0x48..0x20), ack each byte -> identical 13-byte sequence, no errors;
//     with IP_UART_RX_PARITY_EN, a corrupted parity bit on 0x4C -> parity_error pulse together with recv_valid.

Source files
------------

// File: rtl/ip_uart_rx.sv
// ip_uart_rx: UART receiver (8 data bits, LSB first, 1 stop bit) with a valid/ack byte handoff.
// Define IP_UART_RX_PARITY_EN to add an even parity bit between the data and stop bits.
module ip_uart_rx #(
   parameter int clk_freq  = 27000000,
   parameter int uart_freq = 115200
) (
   input  logic       sys_clk,
   input  logic       w_n_reset,
   input  logic       uart_rx,
   output logic [7:0] recv_data,
   output logic       recv_valid,
   input  logic       recv_ack,
   output logic       framing_error,
   output logic       overrun,
   output logic       parity_error
);
   localparam int DIV   = clk_freq / uart_freq;
   localparam int HALF  = DIV / 2;
   localparam int CNT_W = $clog2(DIV);
   localparam logic [CNT_W-1:0] DIV_M1  = CNT_W'(DIV - 1);
   localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(HALF - 1);

   typedef enum logic [2:0] {
      IDLE, START, DATA, STOP, BREAK
`ifdef IP_UART_RX_PARITY_EN
      , PARITY
`endif
   } state_t;

   logic             sync1, sync2;
   logic [2:0]       hist;
   logic             sample_bit;
   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       idx;
   logic [7:0]       shift;
`ifdef IP_UART_RX_PARITY_EN
   logic             parity_bad;
`endif

   always_ff @(posedge sys_clk or negedge w_n_reset) begin
      if (!w_n_reset) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
         hist  <= 3'b111;
      end else begin
         sync1 <= uart_rx;
         sync2 <= sync1;
         hist  <= {hist[1:0], sync2};
      end
   end

   // Majority vote rejects a single-cycle glitch at the sample point.
   assign sample_bit = (hist[0] & hist[1]) | (hist[0] & hist[2]) | (hist[1] & hist[2]);

   always_ff @(posedge sys_clk or negedge w_n_reset) begin
      if (!w_n_reset) begin
         state         <= IDLE;
         cnt           <= '0;
         idx           <= 3'd0;
         shift         <= 8'h00;
         recv_data     <= 8'h00;
         recv_valid    <= 1'b0;
         framing_error <= 1'b0;
         overrun       <= 1'b0;
`ifdef IP_UART_RX_PARITY_EN
         parity_bad    <= 1'b0;
         parity_error  <= 1'b0;
`endif
      end else begin
         framing_error <= 1'b0;
`ifdef IP_UART_RX_PARITY_EN
         parity_error  <= 1'b0;
`endif
         if (recv_ack && recv_valid) begin
            recv_valid <= 1'b0;
            overrun    <= 1'b0;
         end
         if (cnt != '0)
            cnt <= cnt - 1'b1;

         case (state)
            IDLE: begin
               if (!sync2) begin
                  cnt   <= HALF_M1;
                  state <= START;
               end
            end
            START: begin
               if (cnt == '0) begin
                  if (sample_bit) begin
                     state <= IDLE;
                  end else begin
                     cnt   <= DIV_M1;
                     idx   <= 3'd0;
                     state <= DATA;
                  end
               end
            end
            DATA: begin
               if (cnt == '0) begin
                  shift[idx] <= sample_bit;
                  cnt        <= DIV_M1;
                  idx        <= idx + 3'd1;
                  if (idx == 3'd7) begin
`ifdef IP_UART_RX_PARITY_EN
                     state <= PARITY;
`else
                     state <= STOP;
`endif
                  end
               end
            end
`ifdef IP_UART_RX_PARITY_EN
            PARITY: begin
               if (cnt == '0) begin
                  parity_bad <= sample_bit ^ (^shift);
                  cnt        <= DIV_M1;
                  state      <= STOP;
               end
            end
`endif
            STOP: begin
               if (cnt == '0) begin
                  if (sample_bit) begin
                     // An ack in this same cycle frees the holding register for the new byte.
                     if (!recv_valid || recv_ack) begin
                        recv_data  <= shift;
                        recv_valid <= 1'b1;
                        overrun    <= 1'b0;
                     end else begin
                        overrun    <= 1'b1;
                     end
`ifdef IP_UART_RX_PARITY_EN
                     parity_error <= parity_bad;
`endif
                     state <= IDLE;
                  end else begin
                     framing_error <= 1'b1;
                     state         <= BREAK;
                  end
               end
            end
            BREAK: begin
               if (sync2)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifndef IP_UART_RX_PARITY_EN
   assign parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_ip_uart_rx.sv
// Directed bench for ip_uart_rx: serial frames driven bit by bit, expected bytes held in a scoreboard queue.
// Honours IP_UART_RX_PARITY_EN when the design is built with it.
module tb_ip_uart_rx;
   localparam int DIV = 27000000 / 115200;

   logic       clk;
   logic       w_n_reset;
   logic       uart_rx;
   logic [7:0] recv_data;
   logic       recv_valid;
   logic       recv_ack;
   logic       framing_error;
   logic       overrun;
   logic       parity_error;

   int tests_run    = 0;
   int tests_failed = 0;
   int fe_count     = 0;
   int pe_count     = 0;
   int pe_aligned   = 0;
   logic [7:0] sb[$];

   ip_uart_rx #(.clk_freq(27000000), .uart_freq(115200)) dut (
      .sys_clk       (clk),
      .w_n_reset     (w_n_reset),
      .uart_rx       (uart_rx),
      .recv_data     (recv_data),
      .recv_valid    (recv_valid),
      .recv_ack      (recv_ack),
      .framing_error (framing_error),
      .overrun       (overrun),
      .parity_error  (parity_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pulse counters for the one-cycle error outputs.
   always @(negedge clk) begin
      if (framing_error) fe_count = fe_count + 1;
      if (parity_error) begin
         pe_count = pe_count + 1;
         if (recv_valid || overrun) pe_aligned = pe_aligned + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_val);
      uart_rx = 1'b0;
      repeat (DIV) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i];
         repeat (DIV) @(negedge clk);
      end
`ifdef IP_UART_RX_PARITY_EN
      uart_rx = ^b;
      repeat (DIV) @(negedge clk);
`endif
      uart_rx = stop_val;
      repeat (DIV) @(negedge clk);
   endtask

`ifdef IP_UART_RX_PARITY_EN
   task automatic send_bad_parity(input logic [7:0] b);
      uart_rx = 1'b0;
      repeat (DIV) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i];
         repeat (DIV) @(negedge clk);
      end
      uart_rx = ~(^b);
      repeat (DIV) @(negedge clk);
      uart_rx = 1'b1;
      repeat (DIV) @(negedge clk);
   endtask
`endif

   task automatic wait_valid(input string tag);
      int n = 0;
      while (!recv_valid && n < 4 * DIV) begin
         @(negedge clk);
         n++;
      end
      check(tag, {31'd0, recv_valid}, 32'd1);
   endtask

   task automatic check_byte(input string tag);
      logic [7:0] exp;
      exp = (sb.size() != 0) ? sb.pop_front() : 8'hxx;
      check(tag, {24'd0, recv_data}, {24'd0, exp});
   endtask

   task automatic pulse_ack();
      recv_ack = 1'b1;
      @(negedge clk);
      recv_ack = 1'b0;
   endtask

   initial begin
      logic [7:0] msg [13];
      int fe_base;
      int pe_base;
      msg = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h21, 8'h20,
              8'h57, 8'h4F, 8'h52, 8'h4C, 8'h44, 8'h20};
      w_n_reset = 1'b0;
      uart_rx   = 1'b1;
      recv_ack  = 1'b0;
      repeat (5) @(negedge clk);
      check("rst_data", {24'd0, recv_data}, 32'h0);
      check("rst_valid", {31'd0, recv_valid}, 32'd0);
      check("rst_ferr", {31'd0, framing_error}, 32'd0);
      check("rst_ovr", {31'd0, overrun}, 32'd0);
      check("rst_perr", {31'd0, parity_error}, 32'd0);
      w_n_reset = 1'b1;
      repeat (20) @(negedge clk);

      // Single byte
      fe_base = fe_count;
      sb.push_back(8'h48);
      send_frame(8'h48, 1'b1);
      wait_valid("t1_valid");
      check_byte("t1_data");
      check("t1_noferr", fe_count - fe_base, 32'd0);
      pulse_ack();
      check("t1_ack_clr", {31'd0, recv_valid}, 32'd0);
      $display("[TB] t1 byte 48 done");

      // Short low glitch is a false start
      fe_base = fe_count;
      uart_rx = 1'b0;
      repeat (50) @(negedge clk);
      uart_rx = 1'b1;
      repeat (3 * DIV) @(negedge clk);
      check("t2_valid", {31'd0, recv_valid}, 32'd0);
      check("t2_noferr", fe_count - fe_base, 32'd0);
      $display("[TB] t2 false start done");

      // Bad stop bit followed by a held-low line
      fe_base = fe_count;
      send_frame(8'h55, 1'b0);
      repeat (2000) @(negedge clk);
      check("t3_one_ferr", fe_count - fe_base, 32'd1);
      check("t3_valid", {31'd0, recv_valid}, 32'd0);
      uart_rx = 1'b1;
      repeat (2 * DIV) @(negedge clk);
      check("t3_no_2nd", {31'd0, recv_valid}, 32'd0);
      sb.push_back(8'h21);
      send_frame(8'h21, 1'b1);
      wait_valid("t3_valid2");
      check_byte("t3_data");
      pulse_ack();
      $display("[TB] t3 framing error then 21 done");

      // Overrun
      sb.push_back(8'h57);
      send_frame(8'h57, 1'b1);
      send_frame(8'h4F, 1'b1);
      repeat (10) @(negedge clk);
      check("t4_valid", {31'd0, recv_valid}, 32'd1);
      check_byte("t4_data");
      check("t4_ovr", {31'd0, overrun}, 32'd1);
      pulse_ack();
      check("t4_ack_valid", {31'd0, recv_valid}, 32'd0);
      check("t4_ack_ovr", {31'd0, overrun}, 32'd0);
      $display("[TB] t4 overrun done");

      // Reset in the middle of a frame while a byte is held
      sb.push_back(8'h11);
      send_frame(8'h11, 1'b1);
      wait_valid("t5_pre_valid");
      check_byte("t5_pre_data");
      uart_rx = 1'b0;
      repeat (DIV) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         uart_rx = (8'hA5 >> i) & 8'h01;
         repeat (DIV) @(negedge clk);
      end
      uart_rx = 1'b0;
      repeat (DIV / 2) @(negedge clk);
      w_n_reset = 1'b0;
      @(negedge clk);
      check("t5_rst_valid", {31'd0, recv_valid}, 32'd0);
      check("t5_rst_data", {24'd0, recv_data}, 32'h0);
      check("t5_rst_ovr", {31'd0, overrun}, 32'd0);
      uart_rx = 1'b1;
      repeat (3) @(negedge clk);
      w_n_reset = 1'b1;
      repeat (DIV) @(negedge clk);
      sb.push_back(8'h3C);
      send_frame(8'h3C, 1'b1);
      wait_valid("t5_valid");
      check_byte("t5_data");
      pulse_ack();
      $display("[TB] t5 reset mid-frame done");

      // Message stream with per-byte ack
      fe_base = fe_count;
      pe_base = pe_count;
      for (int i = 0; i < 13; i++) begin
         sb.push_back(msg[i]);
         send_frame(msg[i], 1'b1);
         wait_valid("t6_valid");
         check_byte("t6_data");
         pulse_ack();
         $display("[TB] t6 byte %0d = %02h", i, msg[i]);
      end
      check("t6_noferr", fe_count - fe_base, 32'd0);
      check("t6_noperr", pe_count - pe_base, 32'd0);
      check("t6_ovr", {31'd0, overrun}, 32'd0);

`ifdef IP_UART_RX_PARITY_EN
      pe_base = pe_count;
      fe_base = pe_aligned;
      sb.push_back(8'h4C);
      send_bad_parity(8'h4C);
      wait_valid("t7_valid");
      check_byte("t7_data");
      check("t7_perr", pe_count - pe_base, 32'd1);
      check("t7_perr_aligned", pe_aligned - fe_base, 32'd1);
      pulse_ack();
      $display("[TB] t7 parity error on 4C done");
`endif

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
